// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel pipeline.
//   - Default widths for the counters, object coordinates and colours.
//   - Default object size.
//   - 800x600 active-area constants and the blanking colour.
//   - A helper that returns the LSB offset of element idx in a packed vector.
package vga_pkg;

  localparam int DEF_CNT_W = 11;
  localparam int DEF_POS_W = 12;
  localparam int DEF_RGB_W = 12;
  localparam int DEF_OBJ_W = 32;
  localparam int DEF_OBJ_H = 32;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  localparam logic [11:0] BLACK = 12'h000;

  // Element idx of width w sits at [slice_lsb(idx, w) +: w].
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/obj_hit_cmp.sv
// Combinational point-in-rectangle test for one object.
//   en_i       object enabled (a disabled object never hits)
//   h_i, v_i   current pixel position
//   x_i, y_i   top-left corner of the object
//   hit_o      1 when (h, v) lies inside the OBJ_W x OBJ_H rectangle
module obj_hit_cmp
  import vga_pkg::*;
#(
  parameter int OBJ_W = DEF_OBJ_W,
  parameter int OBJ_H = DEF_OBJ_H,
  parameter int POS_W = DEF_POS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             en_i,
  input  logic [CNT_W-1:0] h_i,
  input  logic [CNT_W-1:0] v_i,
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  output logic             hit_o
);

  // All compares run one bit wider than the coordinates so that the far
  // edge of an object near 4095 never wraps back to column/line 0.
  logic [POS_W:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;

  assign h_ext = (POS_W+1)'(h_i);
  assign v_ext = (POS_W+1)'(v_i);
  assign x_ext = {1'b0, x_i};
  assign y_ext = {1'b0, y_i};
  assign x_end = x_ext + (POS_W+1)'(OBJ_W);
  assign y_end = y_ext + (POS_W+1)'(OBJ_H);

  assign hit_o = en_i && (h_ext >= x_ext) && (h_ext < x_end) &&
                 (v_ext >= y_ext) && (v_ext < y_end);

endmodule

// File: rtl/draw_obj_layer.sv
// Overlay stage painting N_OBJ rectangles over the upstream pixel stream.
//   pclk, rst_n              pixel clock, async active-low reset
//   hcount_in .. vblnk_in    timing bundle in; *_out is the same, 2 pclk later
//   rgb_in / rgb_out         upstream pixel / composited pixel (2 pclk later)
//   obj_x, obj_y, obj_color  packed per-object position and colour
//   obj_en                   per-object enable
//   coll_flags               bit k: player (object 0) overlapped object k last frame
//   coll_valid               one-cycle pulse when coll_flags is refreshed
// Object inputs are sampled once per frame at the vblank rising edge, so the
// producer may update them at any time without tearing.
module draw_obj_layer
  import vga_pkg::*;
#(
  parameter int N_OBJ = 4,
  parameter int OBJ_W = DEF_OBJ_W,
  parameter int OBJ_H = DEF_OBJ_H,
  parameter int CNT_W = DEF_CNT_W,
  parameter int POS_W = DEF_POS_W,
  parameter int RGB_W = DEF_RGB_W
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       hcount_in,
  input  logic [CNT_W-1:0]       vcount_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   hblnk_in,
  input  logic                   vblnk_in,
  input  logic [RGB_W-1:0]       rgb_in,
  input  logic [N_OBJ*POS_W-1:0] obj_x,
  input  logic [N_OBJ*POS_W-1:0] obj_y,
  input  logic [N_OBJ*RGB_W-1:0] obj_color,
  input  logic [N_OBJ-1:0]       obj_en,
  output logic [CNT_W-1:0]       hcount_out,
  output logic [CNT_W-1:0]       vcount_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   hblnk_out,
  output logic                   vblnk_out,
  output logic [RGB_W-1:0]       rgb_out,
  output logic [N_OBJ-1:0]       coll_flags,
  output logic                   coll_valid
);

  // Stage-1 registers
  logic [CNT_W-1:0] hcount_q, vcount_q;
  logic             hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [RGB_W-1:0] rgb_q;

  // Per-frame shadow copies of the object inputs
  logic [N_OBJ*POS_W-1:0] sh_x_q, sh_y_q;
  logic [N_OBJ*RGB_W-1:0] sh_color_q;
  logic [N_OBJ-1:0]       sh_en_q;

  logic [N_OBJ-1:0] acc_q, acc_d;
  logic [N_OBJ-1:0] hit;
  logic [RGB_W-1:0] rgb_d;
  logic             shadow_load, report, active;

  // vblnk_q is the registered vblnk_in; vblnk_out is the registered stage-1 vblnk.
  assign shadow_load = vblnk_in & ~vblnk_q;
  assign report      = vblnk_q & ~vblnk_out;
  assign active      = ~hblnk_q & ~vblnk_q;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
    obj_hit_cmp #(
      .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .POS_W(POS_W), .CNT_W(CNT_W)
    ) u_cmp (
      .en_i (sh_en_q[g]),
      .h_i  (hcount_q),
      .v_i  (vcount_q),
      .x_i  (sh_x_q[slice_lsb(g, POS_W) +: POS_W]),
      .y_i  (sh_y_q[slice_lsb(g, POS_W) +: POS_W]),
      .hit_o(hit[g])
    );
  end

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    rgb_d = rgb_q;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (hit[k]) rgb_d = sh_color_q[slice_lsb(k, RGB_W) +: RGB_W];
    end
    if (!active) rgb_d = RGB_W'(BLACK);
  end

  // Report and accumulation are mutually exclusive: report only happens in vblank.
  always_comb begin
    acc_d = acc_q;
    if (report) begin
      acc_d = '0;
    end else if (active) begin
      for (int k = 1; k < N_OBJ; k++) begin
        acc_d[k] = acc_q[k] | (hit[0] & hit[k]);
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      hblnk_q    <= 1'b0;
      vblnk_q    <= 1'b0;
      rgb_q      <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_color_q <= '0;
      sh_en_q    <= '0;
      acc_q      <= '0;
      coll_flags <= '0;
      coll_valid <= 1'b0;
    end else begin
      hcount_q   <= hcount_in;
      vcount_q   <= vcount_in;
      hsync_q    <= hsync_in;
      vsync_q    <= vsync_in;
      hblnk_q    <= hblnk_in;
      vblnk_q    <= vblnk_in;
      rgb_q      <= rgb_in;
      hcount_out <= hcount_q;
      vcount_out <= vcount_q;
      hsync_out  <= hsync_q;
      vsync_out  <= vsync_q;
      hblnk_out  <= hblnk_q;
      vblnk_out  <= vblnk_q;
      rgb_out    <= rgb_d;
      if (shadow_load) begin
        sh_x_q     <= obj_x;
        sh_y_q     <= obj_y;
        sh_color_q <= obj_color;
        sh_en_q    <= obj_en;
      end
      acc_q      <= acc_d;
      coll_valid <= report;
      if (report) coll_flags <= acc_q;
    end
  end

endmodule

// File: tb/tb_draw_obj_layer.sv
module tb_draw_obj_layer;

  localparam int N_OBJ = 4;
  localparam int CNT_W = 11;
  localparam int POS_W = 12;
  localparam int RGB_W = 12;
  localparam int EW    = 2*CNT_W + 4 + RGB_W;

  typedef struct {
    int          fr;
    int          h;
    int          v;
    bit          hb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  logic                   pclk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [CNT_W-1:0]       hcount_in = '0, vcount_in = '0;
  logic                   hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [RGB_W-1:0]       rgb_in = '0;
  logic [N_OBJ*POS_W-1:0] obj_x = '0, obj_y = '0;
  logic [N_OBJ*RGB_W-1:0] obj_color = '0;
  logic [N_OBJ-1:0]       obj_en = '0;
  logic [CNT_W-1:0]       hcount_out, vcount_out;
  logic                   hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [RGB_W-1:0]       rgb_out;
  logic [N_OBJ-1:0]       coll_flags;
  logic                   coll_valid;

  logic [EW-1:0] exp_q[$];
  vec_t          vt[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            pulse_cnt = 0;
  logic [N_OBJ-1:0] last_flags = '0;

  // clock / reset block
  always #5 pclk = ~pclk;

  draw_obj_layer #(.N_OBJ(N_OBJ)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .obj_x(obj_x), .obj_y(obj_y), .obj_color(obj_color), .obj_en(obj_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .coll_flags(coll_flags), .coll_valid(coll_valid)
  );

  function automatic logic [EW-1:0] out_bundle();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_obj(input int k, input int x, input int y, input logic [11:0] c);
    obj_x[k*POS_W +: POS_W]     = POS_W'(x);
    obj_y[k*POS_W +: POS_W]     = POS_W'(y);
    obj_color[k*RGB_W +: RGB_W] = c;
  endtask

  // One pixel per call: sample at the falling edge, check the bundle driven
  // two cycles earlier, then drive the next pixel.
  task automatic tick(input int h, input int v, input bit hb, input bit vb,
                      input logic [11:0] rgb, input logic [11:0] exp_rgb);
    logic [CNT_W-1:0] hh, vv;
    logic [EW-1:0]    e;
    @(negedge pclk);
    if (coll_valid === 1'b1) begin
      pulse_cnt++;
      last_flags = coll_flags;
    end
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("bundle", 64'(out_bundle()), 64'(e));
    end
    hh = CNT_W'(h);
    vv = CNT_W'(v);
    hcount_in = hh;
    vcount_in = vv;
    hsync_in  = hh[3];
    vsync_in  = vv[2];
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    exp_q.push_back({hh, vv, hh[3], vv[2], hb, vb, exp_rgb});
  endtask

  task automatic run_frame(input int fr);
    foreach (vt[i]) begin
      if (vt[i].fr == fr) tick(vt[i].h, vt[i].v, vt[i].hb, 1'b0, vt[i].rgb, vt[i].exp);
    end
  endtask

  task automatic vblank(input logic [N_OBJ-1:0] exp_flags);
    pulse_cnt = 0;
    for (int i = 0; i < 6; i++) tick(0, 600 + i, 1'b1, 1'b1, 12'h0F0, 12'h000);
    check("coll_valid_pulses", 64'(pulse_cnt), 64'd1);
    check("coll_flags_report", 64'(last_flags), 64'(exp_flags));
    check("coll_flags_hold", 64'(coll_flags), 64'(exp_flags));
  endtask

  function automatic void add(input int fr, input int h, input int v, input bit hb,
                              input logic [11:0] rgb, input logic [11:0] exp);
    vec_t t;
    t.fr = fr; t.h = h; t.v = v; t.hb = hb; t.rgb = rgb; t.exp = exp;
    vt.push_back(t);
  endfunction

  initial begin
    // idle, no objects
    add(1, 0, 0, 0, 12'h0F0, 12'h0F0);     add(1, 400, 300, 0, 12'h0F0, 12'h0F0);
    add(1, 799, 599, 0, 12'h123, 12'h123); add(1, 900, 10, 1, 12'h0F0, 12'h000);
    // object 1 applied mid-frame: not yet visible
    add(2, 100, 50, 0, 12'h0F0, 12'h0F0);  add(2, 115, 60, 0, 12'h0F0, 12'h0F0);
    // object 1 at (100,50): edges
    add(3, 100, 50, 0, 12'h0F0, 12'hF00);  add(3, 131, 81, 0, 12'h0F0, 12'hF00);
    add(3, 99, 50, 0, 12'h0F0, 12'h0F0);   add(3, 132, 50, 0, 12'h0F0, 12'h0F0);
    add(3, 100, 82, 0, 12'h0F0, 12'h0F0);  add(3, 100, 49, 0, 12'h0F0, 12'h0F0);
    add(3, 131, 50, 0, 12'h123, 12'hF00);  add(3, 100, 60, 1, 12'h0F0, 12'h000);
    // object 1 at (100,290), x changed to 300 at line 300
    add(5, 100, 290, 0, 12'h0F0, 12'hF00); add(5, 120, 299, 0, 12'h0F0, 12'hF00);
    add(6, 100, 300, 0, 12'h0F0, 12'hF00); add(6, 131, 310, 0, 12'h0F0, 12'hF00);
    add(6, 300, 300, 0, 12'h0F0, 12'h0F0);
    add(7, 300, 300, 0, 12'h0F0, 12'hF00); add(7, 100, 300, 0, 12'h0F0, 12'h0F0);
    add(7, 331, 321, 0, 12'h0F0, 12'hF00); add(7, 332, 300, 0, 12'h0F0, 12'h0F0);
    // player (200,200) over object 2 (220,210)
    add(8, 225, 215, 0, 12'h0F0, 12'hFFF); add(8, 200, 200, 0, 12'h0F0, 12'hFFF);
    add(8, 240, 235, 0, 12'h0F0, 12'h00F); add(8, 251, 241, 0, 12'h0F0, 12'h00F);
    add(8, 252, 241, 0, 12'h0F0, 12'h0F0); add(8, 231, 231, 0, 12'h0F0, 12'hFFF);
    // object 2 moved to (400,400)
    add(9, 225, 215, 0, 12'h0F0, 12'hFFF); add(9, 400, 400, 0, 12'h0F0, 12'h00F);
    add(9, 431, 431, 0, 12'h0F0, 12'h00F);
    // object 3 at (4090,590): no wrap onto the left edge
    add(10, 0, 590, 0, 12'h0F0, 12'h0F0);  add(10, 25, 595, 0, 12'h0F0, 12'h0F0);
    add(10, 5, 599, 0, 12'h123, 12'h123);
    // object 3 at (780,590): clipped at the right/bottom edge
    add(11, 780, 590, 0, 12'h0F0, 12'h0AA); add(11, 799, 599, 0, 12'h0F0, 12'h0AA);
    add(11, 779, 590, 0, 12'h0F0, 12'h0F0); add(11, 780, 589, 0, 12'h0F0, 12'h0F0);
    add(11, 800, 590, 1, 12'h0F0, 12'h000);
    // player + object 3 at (210,210), then reset mid-frame
    add(12, 200, 200, 0, 12'h0F0, 12'hFFF); add(12, 215, 215, 0, 12'h0F0, 12'hFFF);
    add(12, 400, 300, 0, 12'h0F0, 12'h0F0);
    // after reset: invisible until the next vblank load
    add(13, 200, 200, 0, 12'h0F0, 12'h0F0); add(13, 215, 215, 0, 12'h0F0, 12'h0F0);
    add(14, 215, 215, 0, 12'h0F0, 12'hFFF); add(14, 241, 241, 0, 12'h0F0, 12'h0AA);
    add(14, 242, 241, 0, 12'h0F0, 12'h0F0);

    // reset state
    repeat (10) @(negedge pclk);
    check("reset_bundle", 64'(out_bundle()), 64'd0);
    check("reset_coll", 64'({coll_flags, coll_valid}), 64'd0);
    rst_n = 1'b1;

    vblank(4'b0000);
    run_frame(1);
    obj_en = 4'b0010;
    set_obj(1, 100, 50, 12'hF00);
    run_frame(2);
    vblank(4'b0000);
    run_frame(3);
    set_obj(1, 100, 290, 12'hF00);
    vblank(4'b0000);
    run_frame(5);
    set_obj(1, 300, 290, 12'hF00);
    run_frame(6);
    vblank(4'b0000);
    run_frame(7);

    obj_en = 4'b0101;
    set_obj(0, 200, 200, 12'hFFF);
    set_obj(2, 220, 210, 12'h00F);
    set_obj(3, 200, 200, 12'hABC);  // disabled, overlapping the player
    vblank(4'b0000);
    run_frame(8);
    set_obj(2, 400, 400, 12'h00F);
    vblank(4'b0100);
    run_frame(9);

    obj_en = 4'b1000;
    set_obj(3, 4090, 590, 12'h0AA);
    vblank(4'b0000);
    run_frame(10);
    set_obj(3, 780, 590, 12'h0AA);
    vblank(4'b0000);
    run_frame(11);

    obj_en = 4'b1001;
    set_obj(3, 210, 210, 12'h0AA);
    vblank(4'b0000);
    run_frame(12);
    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_bundle", 64'(out_bundle()), 64'd0);
    check("async_reset_coll", 64'({coll_flags, coll_valid}), 64'd0);
    exp_q.delete();
    @(negedge pclk);
    rst_n = 1'b1;
    run_frame(13);
    vblank(4'b0000);
    run_frame(14);
    vblank(4'b1000);
    tick(0, 0, 1'b1, 1'b1, 12'h000, 12'h000);
    tick(0, 0, 1'b1, 1'b1, 12'h000, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
